// File: rtl/sevenseg_scan_ctrl_if.sv
// Load handshake bundle between a display-word producer and sevenseg_scan_ctrl.
interface sevenseg_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                load;
    logic [4*NDIG-1:0]   value;
    logic [NDIG-1:0]     dp_mask;
    logic                ready;

    modport master (output load, output value, output dp_mask, input ready);
    modport slave  (input load, input value, input dp_mask, output ready);
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_ctrl #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    sevenseg_scan_ctrl_if.slave bus,
    input  logic              blank_all,
    output logic [5:0]        digit_data,
    output logic [NDIG-1:0]   an_n,
    output logic              frame_tick
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;

    buf_state_e          buf_q, buf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*NDIG-1:0]   act_val_q, act_val_d;
    logic [NDIG-1:0]     act_dp_q, act_dp_d;
    logic [4*NDIG-1:0]   pend_val_q, pend_val_d;
    logic [NDIG-1:0]     pend_dp_q, pend_dp_d;
    logic [NDIG-1:0]     an_n_q, an_n_d;
    logic [5:0]          data_q, data_d;
    logic                tick_q, tick_d;
    logic                boundary;
    logic                lz_blank;

`ifdef SEVENSEG_LZB_EN
    logic [NDIG-1:0] lz_vec;
    logic            zero_above;

    // Walk from the most significant digit down; a digit blanks while every nibble above and including it is zero.
    always_comb begin
        lz_vec     = '0;
        zero_above = 1'b1;
        for (int unsigned k = NDIG - 1; k > 0; k--) begin
            zero_above = zero_above & (act_val_q[4*k +: 4] == 4'h0);
            lz_vec[k]  = zero_above;
        end
    end

    assign lz_blank = lz_vec[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    assign boundary = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q      <= BUF_EMPTY;
            cnt_q      <= '0;
            idx_q      <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            an_n_q     <= '1;
            data_q     <= 6'h20;
            tick_q     <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            an_n_q     <= an_n_d;
            data_q     <= data_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        buf_d      = buf_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        tick_d     = 1'b0;

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        unique case (buf_q)
            BUF_EMPTY: begin
                if (bus.load) begin
                    pend_val_d = bus.value;
                    pend_dp_d  = bus.dp_mask;
                    buf_d      = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (boundary) begin
                    act_val_d = pend_val_q;
                    act_dp_d  = pend_dp_q;
                    buf_d     = BUF_EMPTY;
                    tick_d    = 1'b1;
                end
            end
            default: buf_d = BUF_EMPTY;
        endcase

        // Slot starts with one dark cycle so the previous digit's segments settle before the next anode turns on.
        an_n_d = '1;
        if (cnt_q != '0) an_n_d[idx_q] = 1'b0;

        data_d = {blank_all | lz_blank, act_dp_q[idx_q], act_val_q[{idx_q, 2'b00} +: 4]};
    end

    assign bus.ready  = (buf_q == BUF_EMPTY);
    assign an_n       = an_n_q;
    assign digit_data = data_q;
    assign frame_tick = tick_q;
endmodule
